// File: rtl/ram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_req_ctrl
// Description : Request/response front-end for a single-port RAM with a
//               registered read port (ram_design, 16x4 by default).
//               Requests (read or write) arrive over a valid/ready handshake
//               and are driven combinationally onto the RAM port, so a write
//               lands in the RAM on the same edge it is accepted. Read data
//               is captured from the RAM's registered data_out one edge
//               later and returned over a valid/ready response channel.
//               Only one read may be outstanding at a time.
//
//               Optional feature macro: RAM_CLEAR_EN
//                 defined   : after reset a clear sequencer writes
//                             CLEAR_VALUE to every RAM location, one per
//                             cycle, before requests are accepted.
//                 undefined : no clear state or counter is built; the block
//                             is ready for requests straight out of reset.
//
// Parameters  : ADDR_W       RAM address width (depth = 2**ADDR_W)
//               DATA_W       RAM data width
//               CLEAR_VALUE  word written by the clear sequencer
//
// Ports       : clk               in   rising-edge clock, shared with RAM
//               rst_n             in   asynchronous active-low reset
//               req_valid         in   request present
//               req_ready         out  request accepted when valid&&ready
//               req_write         in   1 = write, 0 = read
//               req_addr          in   request address
//               req_wdata         in   write data (ignored for reads)
//               rsp_valid         out  read data available
//               rsp_ready         in   consumer takes rsp_rdata
//               rsp_rdata         out  read data, stable while stalled
//               ram_write_enable  out  to RAM write_enable
//               ram_address       out  to RAM address
//               ram_data_in       out  to RAM data_in
//               ram_data_out      in   from RAM data_out (registered)
//               busy              out  clear in progress or read in flight
//
// Revision    : 1.0  initial release
// ============================================================================
module ram_req_ctrl #(
    parameter int                ADDR_W      = 4,
    parameter int                DATA_W      = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,

    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,

    // RAM port
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,

    // status
    output logic              busy
);

    // ------------------------------------------------------------------------
    // State encoding. RUN is terminal until reset; CLEAR only exists as a
    // real flop state when the clear sequencer is built.
    // ------------------------------------------------------------------------
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        w_state;
    logic [ADDR_W-1:0] w_clr_addr;

`ifdef RAM_CLEAR_EN
    // The counter is one bit wider than the address so that the terminal
    // count compare looks at the full value and cannot alias on wrap.
    localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CLR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [ADDR_W:0] clr_cnt_q;
    logic [ADDR_W:0] clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + CLR_ONE;
            // Leave CLEAR on the same edge that writes the last location.
            if (clr_cnt_q == CLR_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign w_state    = state_q;
    assign w_clr_addr = clr_cnt_q[ADDR_W-1:0];
`else
    // No sequencer: the block behaves as if permanently in RUN. The clear
    // address is a tied-off constant so the RAM drive mux below folds away.
    assign w_state    = ST_RUN;
    assign w_clr_addr = '0;
`endif

    // ------------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------------
    logic              rd_pending_q;
    logic              rd_pending_d;
    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] rsp_rdata_d;

    logic w_run;
    logic w_rsp_free;
    logic w_req_ready;
    logic w_accept;

    assign w_run       = (w_state == ST_RUN);
    // The response slot is free if empty, or if it is being popped now.
    assign w_rsp_free  = !rsp_valid_q || rsp_ready;
    // A read in flight blocks new requests: its capture needs the response
    // slot on the next edge, and keeping req_ready low guarantees that a
    // capture and a pop never collide.
    assign w_req_ready = w_run && !rd_pending_q && w_rsp_free;
    assign w_accept    = req_valid && w_req_ready;

    // ------------------------------------------------------------------------
    // Read pipeline and response register
    // ------------------------------------------------------------------------
    always_comb begin
        rd_pending_d = w_accept && !req_write;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        if (rd_pending_q) begin
            // RAM registered data_out on the accept edge; take it now.
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ram_data_out;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            rd_pending_q <= rd_pending_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // ------------------------------------------------------------------------
    // RAM drive: sequencer owns the port during CLEAR, requester otherwise.
    // ------------------------------------------------------------------------
    always_comb begin
        ram_write_enable = 1'b0;
        ram_address      = req_addr;
        ram_data_in      = req_wdata;
        if (!w_run) begin
            ram_write_enable = 1'b1;
            ram_address      = w_clr_addr;
            ram_data_in      = CLEAR_VALUE;
        end else begin
            ram_write_enable = w_accept && req_write;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready = w_req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = !w_run || rd_pending_q;

endmodule
`default_nettype wire
